upsample_multi: RTL and testbench
=================================

# upsample_multi

Multi-channel, run-time configurable interpolator front end: inserts L-1 zeros (or holds the sample, optional) between input samples for every channel in lockstep. It adds a programmable output phase delay. It sits between the low-rate sample source and the CIC/FIR interpolation integrator chain, clocked at the high rate and stepped by a clock enable.

## Interface
- gp_data_width, 8, per-channel sample width, signed two's complement
- gp_nr_channels, 2, number of parallel channels
- gp_max_factor, 8, maximum upsampling factor L (≥2)
- i_clk  in  1  rising-edge clock
- i_rst_an  in  1  reset, asynchronous, active-low
- i_ena  in  1  high-rate tick; all state advances only when high
- i_factor  in  $clog2(gp_max_factor)+1  requested L
- i_phase  in  $clog2(gp_max_factor)  requested output delay in ticks
- i_mode  in  1  0 = zero insertion, 1 = zero-order hold
- i_data  in  gp_nr_channels*gp_data_width  channel 0 in LSBs
- o_load  out  1  high when the current tick is a load tick; upstream must present i_data then
- o_data  out  gp_nr_channels*gp_data_width  upsampled samples, same packing
- o_fill_done  out  1  delay line filled since reset; sticky

## Operation
- Frame counter r_cnt counts 0..L_eff-1 on enabled ticks, then wraps to 0; o_load = (r_cnt==0), decoded from the register only.
- Load tick (r_cnt==0 && i_ena): i_factor, i_phase, i_mode captured into shadow registers; the tick itself uses the new values. Changes on non-load ticks are ignored until the next load tick.
- Clamping: i_factor==0 → L_eff=1; i_factor>gp_max_factor → L_eff=gp_max_factor; L_eff=1 is pass-through (every tick is a load tick).
- Stage 1 per channel, on enabled tick: load → i_data; else mode 0 → 0; mode 1 → hold previous value.
- Stage 2: per-channel tapped delay line of gp_max_factor-1 registers shifting on i_ena; o_data = tap selected by phase shadow (phase 0 = stage 1 output directly).
- o_fill_done rises once (phase_eff+1) enabled ticks have elapsed since reset; stays high until reset.
- Channels never interact; no arithmetic, no width growth.

## Timing
- Reset: r_cnt=0, shadows L=1/phase 0/mode 0, all data registers 0, o_data=0, o_fill_done=0, o_load=1.
- Latency: sample loaded at enabled tick t appears on o_data after the edge of enabled tick t+phase_eff; i.e., 1 enabled tick + phase delay.
- i_ena low: all registers hold, o_data and o_load stable.
- Phase change at a load tick retaps immediately; stale delay-line contents may appear for up to phase_eff ticks (no flush).
- Reset mid-frame: asynchronous clear; first enabled tick after release is a load tick.

## Configuration
- UPSAMPLE_MULTI_HOLD_EN defined: i_mode honoured; zero-order hold available.
- Not defined: i_mode ignored, hold logic absent, always zero insertion; mode shadow register removed.

## Structure
- Package upsample_multi_pkg: counter/phase width constants, clamp function for L_eff, mode localparams (ZERO_INS, ZOH).
- Sub-module upsample_tap_delay: one channel's enabled shift chain plus tap mux, built from existing dff cells; instantiated gp_nr_channels times.

## Test plan
- Reset, ch0=5, ch1=-3 held, L=4, phase 0, mode 0 → o_load 1,0,0,0 repeating; o_data ch0 = 5,0,0,0, ch1 = -3,0,0,0; o_fill_done high after 1st tick.
- L=4, phase 3 → same pattern delayed 3 enabled ticks; o_fill_done rises after 4th enabled tick.
- Mode 1 (HOLD_EN), L=3, inputs 7 then 9 → o_data 7,7,7,9,9,9.
- i_factor 4→2 driven mid-frame at r_cnt=1 → current frame finishes at 4 ticks, next frame is 2.
- i_factor=0 → pass-through, o_load constantly 1; i_factor=15 with gp_max_factor=8 → period 8.
- i_ena toggled 1-0-1 and reset asserted at r_cnt=2 → outputs frozen while low; after reset all zero, o_load=1.

Source files
------------

// File: rtl/upsample_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : upsample_multi_pkg
// Description : Shared constants and helpers for the multi-channel upsampler.
//               Holds the mode encodings, the counter/phase width helpers and
//               the factor clamp that turns a requested L into L_eff.
// Revision    : 1.0 - initial release
// ============================================================================
package upsample_multi_pkg;

    // Stage-1 fill behaviour between load ticks.
    localparam logic ZERO_INS = 1'b0;
    localparam logic ZOH      = 1'b1;

    // Width of the requested/effective factor (must be able to hold max_factor).
    function automatic int factor_width(input int max_factor);
        return $clog2(max_factor) + 1;
    endfunction

    // Width of the phase select and of the frame counter (0..max_factor-1).
    function automatic int phase_width(input int max_factor);
        return $clog2(max_factor);
    endfunction

    // 0 is treated as pass-through (L_eff = 1); anything above the
    // supported maximum saturates at the maximum.
    function automatic int clamp_factor(input int req, input int max_factor);
        if (req == 0) begin
            return 1;
        end else if (req > max_factor) begin
            return max_factor;
        end
        return req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/upsample_tap_delay.sv
`default_nettype none
// ============================================================================
// Module      : upsample_tap_delay
// Description : One channel's enabled shift chain with a tap multiplexer.
//               Select 0 passes the input straight through; select k returns
//               the value the input held k enabled ticks earlier.
// Ports       : i_clk     - rising-edge clock
//               i_rst_an  - asynchronous active-low reset
//               i_ena     - shift enable (high-rate tick)
//               i_din     - chain input (stage-1 output)
//               i_sel     - tap select, 0..DEPTH
//               o_dout    - selected tap
// Revision    : 1.0 - initial release
// ============================================================================
module upsample_tap_delay #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 7,
    parameter int SEL_W  = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_an,
    input  logic              i_ena,
    input  logic [DATA_W-1:0] i_din,
    input  logic [SEL_W-1:0]  i_sel,
    output logic [DATA_W-1:0] o_dout
);

    logic [DATA_W-1:0] r_taps [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            always_ff @(posedge i_clk or negedge i_rst_an) begin
                if (!i_rst_an) begin
                    r_taps[k] <= '0;
                end else if (i_ena) begin
                    r_taps[k] <= i_din;
                end
            end
        end else begin : g_next
            always_ff @(posedge i_clk or negedge i_rst_an) begin
                if (!i_rst_an) begin
                    r_taps[k] <= '0;
                end else if (i_ena) begin
                    r_taps[k] <= r_taps[k-1];
                end
            end
        end
    end

    always_comb begin
        o_dout = i_din;
        for (int k = 1; k <= DEPTH; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_dout = r_taps[k-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/upsample_multi.sv
`default_nettype none
// ============================================================================
// Module      : upsample_multi
// Description : Multi-channel interpolator front end. Inserts L_eff-1 zeros
//               (or holds the sample) between input samples on every channel
//               in lockstep, then applies a programmable output phase delay.
//               Factor, phase and mode are sampled only on load ticks.
// Config      : UPSAMPLE_MULTI_HOLD_EN - when defined, i_mode selects
//               zero-order hold; otherwise zero insertion only.
// Ports       : i_clk       - rising-edge clock (high rate)
//               i_rst_an    - asynchronous active-low reset
//               i_ena       - high-rate tick, all state advances on it
//               i_factor    - requested L (clamped to 1..gp_max_factor)
//               i_phase     - requested output delay in ticks
//               i_mode      - 0 zero insertion, 1 zero-order hold
//               i_data      - packed input samples, channel 0 in LSBs
//               o_load      - current tick is a load tick
//               o_data      - packed upsampled samples
//               o_fill_done - sticky, delay line filled since reset
// Revision    : 1.0 - initial release
// ============================================================================
module upsample_multi
    import upsample_multi_pkg::*;
#(
    parameter int gp_data_width  = 8,
    parameter int gp_nr_channels = 2,
    parameter int gp_max_factor  = 8
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst_an,
    input  logic                                    i_ena,
    input  logic [$clog2(gp_max_factor):0]          i_factor,
    input  logic [$clog2(gp_max_factor)-1:0]        i_phase,
    input  logic                                    i_mode,
    input  logic [gp_nr_channels*gp_data_width-1:0] i_data,
    output logic                                    o_load,
    output logic [gp_nr_channels*gp_data_width-1:0] o_data,
    output logic                                    o_fill_done
);

    localparam int c_FACTOR_W = factor_width(gp_max_factor);
    localparam int c_PHASE_W  = phase_width(gp_max_factor);
    localparam int c_CNT_W    = c_PHASE_W;

    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_FACTOR_W-1:0] r_factor;
    logic [c_PHASE_W-1:0]  r_phase;
    logic [c_PHASE_W-1:0]  r_ticks;
    logic                  r_fill;

    logic                  w_load;
    logic                  w_load_tick;
    logic [c_FACTOR_W-1:0] w_factor_req;
    logic [c_PHASE_W-1:0]  w_phase_req;
    logic [c_FACTOR_W-1:0] w_factor_use;
    logic [c_PHASE_W-1:0]  w_phase_use;
    logic                  w_last;

    // Load decode comes from the counter register only, so o_load is
    // glitch-free and valid before the tick it announces.
    assign w_load      = (r_cnt == '0);
    assign w_load_tick = w_load & i_ena;

    assign w_factor_req = c_FACTOR_W'(clamp_factor(int'(i_factor), gp_max_factor));
    assign w_phase_req  = (int'(i_phase) > gp_max_factor - 1)
                        ? c_PHASE_W'(gp_max_factor - 1) : i_phase;

    // On a load tick the freshly requested settings already govern that tick.
    assign w_factor_use = w_load ? w_factor_req : r_factor;
    assign w_phase_use  = w_load ? w_phase_req  : r_phase;
    assign w_last       = (c_FACTOR_W'(r_cnt) == w_factor_use - c_FACTOR_W'(1));

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            r_cnt    <= '0;
            r_factor <= c_FACTOR_W'(1);
            r_phase  <= '0;
        end else if (i_ena) begin
            r_cnt <= w_last ? '0 : r_cnt + c_CNT_W'(1);
            if (w_load) begin
                r_factor <= w_factor_req;
                r_phase  <= w_phase_req;
            end
        end
    end

    // r_ticks holds the number of earlier enabled ticks; it stops counting
    // once the flag is set, and never exceeds the phase it is compared with.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            r_ticks <= '0;
            r_fill  <= 1'b0;
        end else if (i_ena && !r_fill) begin
            if (r_ticks >= w_phase_use) begin
                r_fill <= 1'b1;
            end else begin
                r_ticks <= r_ticks + c_PHASE_W'(1);
            end
        end
    end

`ifdef UPSAMPLE_MULTI_HOLD_EN
    logic r_mode;
    logic w_mode_use;

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            r_mode <= ZERO_INS;
        end else if (w_load_tick) begin
            r_mode <= i_mode;
        end
    end

    assign w_mode_use = w_load ? i_mode : r_mode;
`else
    logic w_unused_mode;
    assign w_unused_mode = i_mode ^ w_load_tick;
`endif

    for (genvar ch = 0; ch < gp_nr_channels; ch++) begin : g_ch
        logic [gp_data_width-1:0] r_s1;
        logic [gp_data_width-1:0] w_tap;

        always_ff @(posedge i_clk or negedge i_rst_an) begin
            if (!i_rst_an) begin
                r_s1 <= '0;
            end else if (i_ena) begin
                if (w_load) begin
                    r_s1 <= i_data[ch*gp_data_width +: gp_data_width];
`ifdef UPSAMPLE_MULTI_HOLD_EN
                end else if (w_mode_use == ZOH) begin
                    r_s1 <= r_s1;
`endif
                end else begin
                    r_s1 <= '0;
                end
            end
        end

        upsample_tap_delay #(
            .DATA_W (gp_data_width),
            .DEPTH  (gp_max_factor - 1),
            .SEL_W  (c_PHASE_W)
        ) u_tap (
            .i_clk    (i_clk),
            .i_rst_an (i_rst_an),
            .i_ena    (i_ena),
            .i_din    (r_s1),
            .i_sel    (r_phase),
            .o_dout   (w_tap)
        );

        assign o_data[ch*gp_data_width +: gp_data_width] = w_tap;
    end

    assign o_load      = w_load;
    assign o_fill_done = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_upsample_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_upsample_multi
// Description : Self-checking bench for upsample_multi. A table of directed
//               vectors, a few multi-cycle sequences and a randomized run are
//               all compared against a history-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_upsample_multi;

    localparam int DW  = 8;
    localparam int NCH = 2;
    localparam int MF  = 8;
    localparam int FW  = $clog2(MF) + 1;
    localparam int PW  = $clog2(MF);
    localparam int VW  = NCH * DW;

    logic          clk    = 1'b0;
    logic          rst_an = 1'b0;
    logic          ena    = 1'b0;
    logic [FW-1:0] factor = '0;
    logic [PW-1:0] phase  = '0;
    logic          mode   = 1'b0;
    logic [VW-1:0] din    = '0;
    logic [VW-1:0] dout;
    logic          load;
    logic          fill;

    always #5 clk = ~clk;

    upsample_multi #(
        .gp_data_width  (DW),
        .gp_nr_channels (NCH),
        .gp_max_factor  (MF)
    ) dut (
        .i_clk       (clk),
        .i_rst_an    (rst_an),
        .i_ena       (ena),
        .i_factor    (factor),
        .i_phase     (phase),
        .i_mode      (mode),
        .i_data      (din),
        .o_load      (load),
        .o_data      (dout),
        .o_fill_done (fill)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frame position, captured settings and the history of
    // stage-1 values (one entry per enabled tick, entry 0 = reset state).
    int            m_cnt;
    int            m_len;
    int            m_ph;
    int            m_ticks;
    logic          m_hold;
    logic          m_fill;
    logic [VW-1:0] m_s1;
    logic [VW-1:0] m_hist [$];

    typedef struct {
        bit            rst;
        logic [FW-1:0] f;
        logic [PW-1:0] p;
        logic [VW-1:0] d;
        logic          e_load;
        logic [VW-1:0] e_data;
        logic          e_fill;
    } vec_t;

    vec_t tbl [16];
    int   exp_mode  [6];
    int   exp_chg   [7];
    logic [VW-1:0] saved_data;
    logic          saved_load;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_len   = 1;
        m_ph    = 0;
        m_ticks = 0;
        m_hold  = 1'b0;
        m_fill  = 1'b0;
        m_s1    = '0;
        m_hist.delete();
        m_hist.push_back('0);
    endtask

    function automatic logic [VW-1:0] m_out();
        int idx;
        idx = m_hist.size() - 1 - m_ph;
        return (idx >= 0) ? m_hist[idx] : '0;
    endfunction

    task automatic model_tick();
        bit ld;
        if (!ena) return;
        ld = (m_cnt == 0);
        if (ld) begin
            m_len = (factor == 0) ? 1 : ((int'(factor) > MF) ? MF : int'(factor));
            m_ph  = (int'(phase) > MF - 1) ? MF - 1 : int'(phase);
`ifdef UPSAMPLE_MULTI_HOLD_EN
            m_hold = mode;
`else
            m_hold = 1'b0;
`endif
            m_s1 = din;
        end else if (!m_hold) begin
            m_s1 = '0;
        end
        m_hist.push_back(m_s1);
        m_cnt = (m_cnt + 1) % m_len;
        m_ticks++;
        if (m_ticks >= m_ph + 1) m_fill = 1'b1;
    endtask

    task automatic model_cmp();
        check("load", 32'(load), 32'(m_cnt == 0));
        check("data", 32'(dout), 32'(m_out()));
        check("fill", 32'(fill), 32'(m_fill));
    endtask

    task automatic step(input logic e);
        ena = e;
        model_tick();
        @(posedge clk);
        #1;
        model_cmp();
    endtask

    task automatic do_reset();
        rst_an = 1'b0;
        #1;
        model_reset();
        check("rst_load", 32'(load), 32'(1));
        check("rst_data", 32'(dout), 32'(0));
        check("rst_fill", 32'(fill), 32'(0));
        @(negedge clk);
        rst_an = 1'b1;
    endtask

    initial begin
        // L=4 phase 0: output right after the load tick, o_load every 4th.
        tbl[0]  = '{1, 4'd4, 3'd0, 16'hFD05, 1'b0, 16'hFD05, 1'b1};
        tbl[1]  = '{0, 4'd4, 3'd0, 16'hFD05, 1'b0, 16'h0000, 1'b1};
        tbl[2]  = '{0, 4'd4, 3'd0, 16'hFD05, 1'b0, 16'h0000, 1'b1};
        tbl[3]  = '{0, 4'd4, 3'd0, 16'hFD05, 1'b1, 16'h0000, 1'b1};
        tbl[4]  = '{0, 4'd4, 3'd0, 16'hFD05, 1'b0, 16'hFD05, 1'b1};
        tbl[5]  = '{0, 4'd4, 3'd0, 16'hFD05, 1'b0, 16'h0000, 1'b1};
        tbl[6]  = '{0, 4'd4, 3'd0, 16'hFD05, 1'b0, 16'h0000, 1'b1};
        tbl[7]  = '{0, 4'd4, 3'd0, 16'hFD05, 1'b1, 16'h0000, 1'b1};
        // L=4 phase 3: same pattern three ticks later, fill after tick 4.
        tbl[8]  = '{1, 4'd4, 3'd3, 16'hFD05, 1'b0, 16'h0000, 1'b0};
        tbl[9]  = '{0, 4'd4, 3'd3, 16'hFD05, 1'b0, 16'h0000, 1'b0};
        tbl[10] = '{0, 4'd4, 3'd3, 16'hFD05, 1'b0, 16'h0000, 1'b0};
        tbl[11] = '{0, 4'd4, 3'd3, 16'hFD05, 1'b1, 16'hFD05, 1'b1};
        tbl[12] = '{0, 4'd4, 3'd3, 16'hFD05, 1'b0, 16'h0000, 1'b1};
        tbl[13] = '{0, 4'd4, 3'd3, 16'hFD05, 1'b0, 16'h0000, 1'b1};
        tbl[14] = '{0, 4'd4, 3'd3, 16'hFD05, 1'b0, 16'h0000, 1'b1};
        tbl[15] = '{0, 4'd4, 3'd3, 16'hFD05, 1'b1, 16'hFD05, 1'b1};
`ifdef UPSAMPLE_MULTI_HOLD_EN
        exp_mode = '{7, 7, 7, 9, 9, 9};
`else
        exp_mode = '{7, 0, 0, 9, 0, 0};
`endif
        exp_chg = '{0, 0, 1, 0, 1, 0, 1};

        model_reset();
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst) do_reset();
            factor = tbl[i].f;
            phase  = tbl[i].p;
            mode   = 1'b0;
            din    = tbl[i].d;
            step(1'b1);
            check("tbl_load", 32'(load), 32'(tbl[i].e_load));
            check("tbl_data", 32'(dout), 32'(tbl[i].e_data));
            check("tbl_fill", 32'(fill), 32'(tbl[i].e_fill));
        end

        // Mode 1, L=3: loads 7 then 9; the 9 between loads must be ignored.
        do_reset();
        factor = 4'd3;
        phase  = '0;
        mode   = 1'b1;
        for (int t = 0; t < 6; t++) begin
            din = (t == 0) ? {8'd7, 8'd7} : {8'd9, 8'd9};
            step(1'b1);
            check("mode_ch0", 32'(dout[7:0]), 32'(exp_mode[t]));
        end

        // Factor 4 -> 2 requested at r_cnt=1: frame of 4 completes first.
        do_reset();
        mode   = 1'b0;
        factor = 4'd4;
        step(1'b1);
        factor = 4'd2;
        for (int t = 0; t < 7; t++) begin
            step(1'b1);
            check("chg_load", 32'(load), 32'(exp_chg[t]));
        end

        // Factor 0: pass-through, every tick loads.
        do_reset();
        factor = 4'd0;
        for (int t = 0; t < 5; t++) begin
            din = VW'($urandom);
            step(1'b1);
            check("pt_load", 32'(load), 32'(1));
            check("pt_data", 32'(dout), 32'(din));
        end

        // Factor 15 saturates at 8.
        do_reset();
        factor = 4'd15;
        for (int t = 1; t <= 16; t++) begin
            step(1'b1);
            check("sat_load", 32'(load), 32'((t % 8) == 0));
        end

        // Enable low freezes everything; reset at r_cnt=2 clears mid-frame.
        do_reset();
        factor = 4'd4;
        din    = 16'h1234;
        step(1'b1);
        step(1'b1);
        saved_data = dout;
        saved_load = load;
        for (int t = 0; t < 3; t++) begin
            din = VW'($urandom);
            step(1'b0);
            check("frz_data", 32'(dout), 32'(saved_data));
            check("frz_load", 32'(load), 32'(saved_load));
        end
        do_reset();
        din = 16'hA55A;
        step(1'b1);
        check("post_rst_data", 32'(dout), 32'(16'hA55A));

        // Randomized run against the model.
        for (int t = 0; t < 800; t++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            factor = FW'($urandom_range(0, 15));
            phase  = PW'($urandom_range(0, MF - 1));
            mode   = 1'($urandom_range(0, 1));
            din    = VW'($urandom);
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
